bcd_down_timer: RTL
===================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV SHALL be >= 2.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 load  input  1  one-cycle request to load load_val.
REQ-006 load_val  input  8  [7:4] tens BCD digit, [3:0] ones BCD digit.
REQ-007 start  input  1  one-cycle request to begin or resume counting.
REQ-008 pause  input  1  one-cycle request to suspend counting.
REQ-009 q_tens  output  4  current tens BCD digit, registered.
REQ-010 q_ones  output  4  current ones BCD digit, registered.
REQ-011 running  output  1  high while in state RUN.
REQ-012 tick  output  1  one-cycle pulse at each count step.
REQ-013 done  output  1  one-cycle pulse when count reaches 00.

Function
REQ-014 States SHALL be IDLE, RUN, HOLD; one FSM, registered state.
REQ-015 Prescaler SHALL count 0..DIV-1 only in RUN; tick SHALL pulse in the cycle the prescaler equals DIV-1, prescaler then wraps to 0.
REQ-016 Prescaler SHALL clear to 0 on IDLE->RUN and SHALL hold its value in HOLD.
REQ-017 On tick, count SHALL decrement by one in BCD: ones 0 wraps to 9 with borrow from tens; updated digits visible the cycle after tick.
REQ-018 When a decrement yields 00, done SHALL pulse in the same cycle the digits become 00 and FSM SHALL enter IDLE.
REQ-019 load in any state SHALL write load_val to digits next cycle and force IDLE; any digit > 9 SHALL be clamped to 9.
REQ-020 load SHALL take priority over start, pause and a coincident tick; that tick's decrement is discarded.
REQ-021 start in IDLE with count != 00 -> RUN; start in IDLE with count 00 SHALL be ignored.
REQ-022 start in HOLD -> RUN; start in RUN ignored.
REQ-023 pause in RUN -> HOLD; pause elsewhere ignored; start and pause together SHALL be ignored.
REQ-024 pause coincident with tick: decrement SHALL occur, then HOLD.
REQ-025 Last loaded value SHALL be retained in a reload register (reset value 00).

Reset
REQ-026 On reset low at a clk edge: state IDLE, q_tens 0, q_ones 0, prescaler 0, reload register 00, running 0, tick 0, done 0.
REQ-027 Reset SHALL override every other input, including mid-count.

Configuration
REQ-028 Macro BCD_TIMER_AUTO_RELOAD_EN: when defined, on reaching 00 done SHALL pulse, digits SHALL load the reload register next cycle and FSM SHALL stay in RUN (reload 00 -> go IDLE); when undefined, behaviour per REQ-018.

Verification (CLK_HZ=10, TICK_HZ=1, DIV=10)
REQ-029 Reset low 2 cycles -> all outputs 0, state IDLE; load 0x12, start -> digits 12,11,10,09,...,00 every 10 cycles, done one pulse, running drops.
REQ-030 Load 0xA7 -> digits 9,7; load 0x00 then start -> stays IDLE, running 0.
REQ-031 Load 0x05, start, pause after 15 cycles -> count 04, holds 30 cycles; start -> next tick after remaining 5 cycles, count 03.
REQ-032 Load 0x30 asserted in tick cycle during RUN -> digits 30, IDLE, no decrement, no done.
REQ-033 Reset low while running at 07 -> all outputs 0 next cycle, no done pulse.
REQ-034 With BCD_TIMER_AUTO_RELOAD_EN: load 0x02, start -> 02,01,00(done),02,01,00(done)..., running stays 1.

Source files
------------

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for the two-digit BCD down-timer.
// Signals: load, load_val[7:0], start, pause in; q_tens, q_ones, running, tick, done out.
interface bcd_down_timer_if;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] q_tens;
    logic [3:0] q_ones;
    logic       running;
    logic       tick;
    logic       done;

    modport master (
        output load, load_val, start, pause,
        input  q_tens, q_ones, running, tick, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output q_tens, q_ones, running, tick, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-timer with IDLE/RUN/HOLD control and a tick prescaler.
// Ports: clk, reset (sync, active low), bus (slave side of bcd_down_timer_if).
// Option: define BCD_TIMER_AUTO_RELOAD_EN to reload from the last loaded value at 00.
// CLK_HZ/TICK_HZ must give a divider of at least 2.
module bcd_down_timer #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input logic             clk,
    input logic             reset,
    bcd_down_timer_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [7:0]    rld_q, rld_d;
    logic          done_q, done_d;

    logic          tick_w;
    logic          last_w;
    logic          zero_w;
    logic          go_w;
    logic          hold_w;
    logic [3:0]    ld_tens;
    logic [3:0]    ld_ones;

    assign ld_tens = (bus.load_val[7:4] > 4'd9) ? 4'd9 : bus.load_val[7:4];
    assign ld_ones = (bus.load_val[3:0] > 4'd9) ? 4'd9 : bus.load_val[3:0];

    assign zero_w = (tens_q == 4'd0) && (ones_q == 4'd0);
    // start and pause together cancel each other
    assign go_w   = bus.start && !bus.pause;
    assign hold_w = bus.pause && !bus.start;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        rld_d   = rld_q;
        done_d  = 1'b0;
        tick_w  = (state_q == RUN) && (presc_q == PW'(DIV - 1));
        // this tick's decrement lands on 00
        last_w  = tick_w && (tens_q == 4'd0) && (ones_q == 4'd1);

        if (bus.load) begin
            state_d = IDLE;
            presc_d = '0;
            tens_d  = ld_tens;
            ones_d  = ld_ones;
            rld_d   = {ld_tens, ld_ones};
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go_w && !zero_w) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                HOLD: begin
                    if (go_w) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    presc_d = tick_w ? '0 : presc_q + 1'b1;
                    if (tick_w) begin
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                    end
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    // 00 is shown for one cycle, then the reload value
                    if (zero_w) begin
                        {tens_d, ones_d} = rld_q;
                    end
                    if (last_w) begin
                        done_d  = 1'b1;
                        state_d = (rld_q == 8'h00) ? IDLE : RUN;
                    end else if (hold_w) begin
                        state_d = HOLD;
                    end
`else
                    if (last_w) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (hold_w) begin
                        state_d = HOLD;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            rld_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            rld_q   <= rld_d;
            done_q  <= done_d;
        end
    end

    assign bus.q_tens  = tens_q;
    assign bus.q_ones  = ones_q;
    assign bus.running = (state_q == RUN);
    assign bus.tick    = tick_w;
    assign bus.done    = done_q;
endmodule
